// File: rtl/rand_arb_pkg.sv
// rand_arb_pkg: shared widths, LFSR constants and helpers for the random-share arbiter
package rand_arb_pkg;
    localparam int RAND_W = 32;
    localparam logic [RAND_W-1:0] LFSR_TAPS = 32'h80200003;
    localparam logic [RAND_W-1:0] LFSR_ONE = 32'h1;

    function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
        return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
    endfunction

    // A zero seed would lock the Galois LFSR, so it is remapped to one
    function automatic logic [RAND_W-1:0] seed_fix(input logic [RAND_W-1:0] s);
        return (s == '0) ? LFSR_ONE : s;
    endfunction

    function automatic int ptr_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/rand_lfsr32.sv
// rand_lfsr32: 32-bit Galois LFSR with reseed port; load takes priority over advance
module rand_lfsr32
    import rand_arb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h00000001
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ADV,
    input  logic              LOAD,
    input  logic [RAND_W-1:0] LOAD_VAL,
    output logic [RAND_W-1:0] Q
);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            Q <= seed_fix(SEED);
        else if (LOAD)
            Q <= seed_fix(LOAD_VAL);
        else if (ADV)
            Q <= lfsr_next(Q);
    end
endmodule

// File: rtl/rand_share_arbiter.sv
// rand_share_arbiter: round-robin sharing of one LFSR among NUM_REQ requesters,
// each with a one-entry response buffer
module rand_share_arbiter
    import rand_arb_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [31:0] SEED    = 32'h00000001
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ_WRITE,
    output logic [NUM_REQ-1:0]        REQ_ACCEPT,
    output logic [RAND_W*NUM_REQ-1:0] RESP_READ,
    output logic [NUM_REQ-1:0]        RESP_READ_VALID,
    input  logic [NUM_REQ-1:0]        RESP_DEQ,
    input  logic                      SEED_LOAD,
    input  logic [RAND_W-1:0]         SEED_VALUE,
    output logic                      DONE
);
    localparam int PW = ptr_w(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      idx;
    logic               found;
    logic [NUM_REQ-1:0] elig;
    logic [RAND_W-1:0]  lfsr;

    // A full buffer may be refilled in the same cycle it is dequeued
    assign elig = REQ_WRITE & (~RESP_READ_VALID | RESP_DEQ);

    always_comb begin
        found = 1'b0;
        win = ptr;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    // Reset suppresses grants asynchronously so no request is taken while buffers are dropped
    assign REQ_ACCEPT = (found && !SEED_LOAD && !RESET) ? NUM_REQ'(1) << win : '0;
    assign DONE = ~|REQ_WRITE && ~|RESP_READ_VALID;

    rand_lfsr32 #(.SEED(SEED)) u_lfsr (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADV      (|REQ_ACCEPT),
        .LOAD     (SEED_LOAD),
        .LOAD_VAL (SEED_VALUE),
        .Q        (lfsr)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr <= PW'(NUM_REQ - 1);
            RESP_READ <= '0;
            RESP_READ_VALID <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (REQ_ACCEPT[i]) begin
                    RESP_READ[RAND_W*i +: RAND_W] <= lfsr;
                    RESP_READ_VALID[i] <= 1'b1;
                end else if (RESP_DEQ[i]) begin
                    RESP_READ_VALID[i] <= 1'b0;
                end
            end
            if (|REQ_ACCEPT)
                ptr <= win;
        end
    end
endmodule

// File: tb/tb_rand_share_arbiter.sv
// tb_rand_share_arbiter: scoreboard bench with a spec-level model of arbitration and the LFSR
module tb_rand_share_arbiter;
    localparam int N = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [N-1:0]  REQ_WRITE = '0;
    logic [N-1:0]  REQ_ACCEPT;
    logic [32*N-1:0] RESP_READ;
    logic [N-1:0]  RESP_READ_VALID;
    logic [N-1:0]  RESP_DEQ = '0;
    logic          SEED_LOAD = 1'b0;
    logic [31:0]   SEED_VALUE = '0;
    logic          DONE;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] exp_q [N][$];
    logic [N-1:0] m_valid;
    int           m_ptr;
    logic [31:0]  m_lfsr;

    rand_share_arbiter #(.NUM_REQ(N), .SEED(32'h00000001)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ_WRITE       (REQ_WRITE),
        .REQ_ACCEPT      (REQ_ACCEPT),
        .RESP_READ       (RESP_READ),
        .RESP_READ_VALID (RESP_READ_VALID),
        .RESP_DEQ        (RESP_DEQ),
        .SEED_LOAD       (SEED_LOAD),
        .SEED_VALUE      (SEED_VALUE),
        .DONE            (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ 32'h80200003 : s >> 1;
    endfunction

    // Reference model: evaluated mid-cycle, predicts this cycle's outputs and the next state
    always @(negedge CLK) begin
        if (RESET) begin
            chk("rst_accept", 32'(REQ_ACCEPT), 32'h0);
            chk("rst_valid", 32'(RESP_READ_VALID), 32'h0);
            m_valid = '0;
            m_ptr = N - 1;
            m_lfsr = 32'h1;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            int w;
            logic [N-1:0] el;
            w = -1;
            el = REQ_WRITE & (~m_valid | RESP_DEQ);
            if (!SEED_LOAD)
                for (int k = 1; k <= N; k++)
                    if (w < 0 && el[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            chk("accept", 32'(REQ_ACCEPT), w >= 0 ? 32'(1) << w : 32'h0);
            chk("valid", 32'(RESP_READ_VALID), 32'(m_valid));
            chk("done", 32'(DONE), 32'(REQ_WRITE == '0 && m_valid == '0));
            m_valid = m_valid & ~RESP_DEQ;
            if (w >= 0) begin
                m_valid[w] = 1'b1;
                exp_q[w].push_back(m_lfsr);
                m_lfsr = step(m_lfsr);
                m_ptr = w;
            end
            if (SEED_LOAD) m_lfsr = (SEED_VALUE == 0) ? 32'h1 : SEED_VALUE;
        end
    end

    // Monitor: every value a requester consumes must match the model's next expected value
    always @(negedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < N; i++) begin
                if (RESP_READ_VALID[i] && RESP_DEQ[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_total++;
                        $display("FAIL resp%0d: got %h, expected nothing queued", i, RESP_READ[32*i +: 32]);
                    end else begin
                        chk($sformatf("resp%0d", i), RESP_READ[32*i +: 32], exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic sl, input logic [31:0] sv);
        REQ_WRITE = r;
        RESP_DEQ = d;
        SEED_LOAD = sl;
        SEED_VALUE = sv;
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] t1_exp [3];

    initial begin
        t1_exp[0] = 32'h00000001;
        t1_exp[1] = 32'h80200003;
        t1_exp[2] = 32'hC0300002;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        cyc('0, '0, 1'b0, '0);

        // 1: three single requests from requester 0
        for (int t = 0; t < 3; t++) begin
            cyc(4'b0001, '0, 1'b0, '0);
            chk($sformatf("t1_val%0d", t), RESP_READ[31:0], t1_exp[t]);
            cyc('0, 4'b0001, 1'b0, '0);
        end

        // 2: everyone requesting, everyone dequeuing
        repeat (8) cyc(4'hF, 4'hF, 1'b0, '0);
        cyc('0, 4'hF, 1'b0, '0);

        // 3: requester 2 holds its buffer, then dequeues and re-requests together
        repeat (6) cyc(4'hF, 4'b1011, 1'b0, '0);
        cyc(4'b0100, 4'b1111, 1'b0, '0);
        cyc('0, 4'hF, 1'b0, '0);

        // 4: reseed with zero while all request
        cyc(4'hF, '0, 1'b1, 32'h0);
        repeat (3) cyc(4'hF, 4'hF, 1'b0, '0);
        cyc('0, 4'hF, 1'b0, '0);

        // 5: reset with full buffers
        repeat (5) cyc(4'hF, '0, 1'b0, '0);
        RESET = 1'b1;
        #1;
        chk("t5_async_valid", 32'(RESP_READ_VALID), 32'h0);
        chk("t5_async_accept", 32'(REQ_ACCEPT), 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        REQ_WRITE = 4'hF;
        RESP_DEQ = '0;
        #1 chk("t5_first", 32'(REQ_ACCEPT), 32'h1);
        repeat (3) cyc(4'hF, 4'hF, 1'b0, '0);
        cyc('0, 4'hF, 1'b0, '0);

        // 6: idle then a single request
        repeat (2) cyc('0, '0, 1'b0, '0);
        chk("t6_idle_done", 32'(DONE), 32'h1);
        REQ_WRITE = 4'b0010;
        #1 chk("t6_req_done", 32'(DONE), 32'h0);
        cyc(4'b0010, '0, 1'b0, '0);
        cyc('0, 4'hF, 1'b0, '0);

        // Random traffic with occasional reseeds
        for (int t = 0; t < 400; t++)
            cyc(4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0,
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
        repeat (3) cyc('0, 4'hF, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
